// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a fixed-length burst from a first-word-fall-through
// FIFO and replays it on a valid/ready stream, tagging the final word and
// pulsing done once the last word has been accepted downstream.
module fifo_burst_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [LEN_WIDTH-1:0]  words_left
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    logic out_accept;
    logic last_pop;

    // Downstream handshake completes this cycle
    assign out_accept = out_valid && out_ready;

    // Pop the head only when it can land in an empty or draining output slot;
    // gated by rst so nothing is consumed while reset is held.
    assign fifo_rd = rst && (state == READ) && !fifo_empty
                     && (words_left != '0) && (!out_valid || out_ready);

    // This pop is the final word of the burst
    assign last_pop = fifo_rd && (words_left == LEN_WIDTH'(1));

    // Burst FSM together with the output word register and word counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            words_left <= '0;
        end else begin
            done <= 1'b0;

            if (fifo_rd) begin
                out_data   <= fifo_data;
                out_valid  <= 1'b1;
                out_last   <= last_pop;
                words_left <= words_left - LEN_WIDTH'(1);
            end else if (out_accept) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            state      <= READ;
                            busy       <= 1'b1;
                            words_left <= burst_len;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (last_pop) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (out_accept && out_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed bench with a behavioural FWFT FIFO, a
// per-cycle vector table for the basic and zero-length bursts, and
// hand-written sequences for backpressure, starvation and mid-burst reset.
module tb_fifo_burst_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [LW-1:0] words_left;

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .words_left (words_left)
    );

    always #5 clk = ~clk;

    // Behavioural FWFT FIFO: head visible combinationally, popped on fifo_rd
    logic [DW-1:0] mem [0:63];
    logic [5:0]    wptr = '0;
    logic [5:0]    rptr = '0;
    assign fifo_empty = (wptr == rptr);
    assign fifo_data  = mem[rptr];

    always @(posedge clk) begin
        if (fifo_rd) rptr <= rptr + 6'd1;
    end

    // Stream monitor: captures accepted words and counts protocol events
    logic [DW-1:0] cap_data [0:255];
    logic          cap_last [0:255];
    int            cap_n        = 0;
    int            done_n       = 0;
    int            stall_rd_n   = 0;
    int            unstable_n   = 0;
    logic          prev_stall   = 1'b0;
    logic [DW-1:0] prev_data    = '0;
    logic          prev_last    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                cap_data[cap_n[7:0]] <= out_data;
                cap_last[cap_n[7:0]] <= out_last;
                cap_n <= cap_n + 1;
            end
            if (done) done_n <= done_n + 1;
            if (fifo_rd && out_valid && !out_ready) stall_rd_n <= stall_rd_n + 1;
            if (prev_stall && (!out_valid || out_data != prev_data || out_last != prev_last))
                unstable_n <= unstable_n + 1;
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
            prev_last  <= out_last;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (act === exp) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wptr] = v;
        wptr = wptr + 6'd1;
    endtask

    // Start a burst, optionally apply the backpressure pattern, wait for done
    task automatic run_burst(input logic [LW-1:0] len, input bit use_bp, input string tag);
        logic pat [0:6];
        bit   got;
        int   d0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        pat[4] = 1'b0; pat[5] = 1'b1; pat[6] = 1'b1;
        got = 1'b0;
        d0  = done_n;
        @(negedge clk);
        start     = 1'b1;
        burst_len = len;
        out_ready = use_bp ? pat[0] : 1'b1;
        @(negedge clk);
        start     = 1'b0;
        burst_len = 8'hFF;
        for (int c = 1; c < 300; c++) begin
            out_ready = (use_bp && c < 7) ? pat[c] : 1'b1;
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, " done reached"}, 32'(got), 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        check({tag, " one done pulse"}, 32'(done_n - d0), 32'd1);
        check({tag, " idle after"}, 32'(busy), 32'd0);
    endtask

    // Compare captured words against base_val+k and the last flag placement
    task automatic check_stream(input int base, input int n, input logic [DW-1:0] base_val,
                                input string tag);
        check({tag, " word count"}, 32'(cap_n - base), 32'(n));
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s data%0d", tag, k), cap_data[8'(base + k)], base_val + DW'(k));
            check($sformatf("%s last%0d", tag, k), 32'(cap_last[8'(base + k)]), 32'(k == n - 1));
        end
    endtask

    typedef struct packed {
        logic          start;
        logic [LW-1:0] len;
        logic          rdy;
        logic          busy;
        logic          done;
        logic          rd;
        logic          ov;
        logic [DW-1:0] od;
        logic          ol;
        logic [LW-1:0] wl;
    } vec_t;

    vec_t vecs [0:10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         base;
        int         d0;
        int         bad;
        logic [5:0] rbase;

        // start len rdy | busy done rd ov od ol wl
        vecs[0]  = '{1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 8'd4};
        vecs[2]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 8'd3};
        vecs[3]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd2, 1'b0, 8'd2};
        vecs[4]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd3, 1'b0, 8'd1};
        vecs[5]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd4, 1'b1, 8'd0};
        vecs[6]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4, 1'b0, 8'd0};
        vecs[7]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4, 1'b0, 8'd0};
        // zero-length burst with a word still waiting in the FIFO
        vecs[8]  = '{1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4, 1'b0, 8'd0};
        vecs[9]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4, 1'b0, 8'd0};
        vecs[10] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4, 1'b0, 8'd0};

        rst       = 1'b0;
        start     = 1'b0;
        burst_len = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset out_valid",  32'(out_valid),  32'd0);
        check("reset out_data",   out_data,        32'd0);
        check("reset out_last",   32'(out_last),   32'd0);
        check("reset done",       32'(done),       32'd0);
        check("reset busy",       32'(busy),       32'd0);
        check("reset words_left", 32'(words_left), 32'd0);

        // Preload while still in reset: no pop may happen
        push(32'd1); push(32'd2); push(32'd3); push(32'd4); push(32'hDEAD);
        #1;
        check("reset fifo_rd", 32'(fifo_rd), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic burst of 4 then a zero-length burst, cycle by cycle
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            start     = vecs[i].start;
            burst_len = vecs[i].len;
            out_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d busy", i),       32'(busy),       32'(vecs[i].busy));
            check($sformatf("vec%0d done", i),       32'(done),       32'(vecs[i].done));
            check($sformatf("vec%0d fifo_rd", i),    32'(fifo_rd),    32'(vecs[i].rd));
            check($sformatf("vec%0d out_valid", i),  32'(out_valid),  32'(vecs[i].ov));
            check($sformatf("vec%0d out_data", i),   out_data,        vecs[i].od);
            check($sformatf("vec%0d out_last", i),   32'(out_last),   32'(vecs[i].ol));
            check($sformatf("vec%0d words_left", i), 32'(words_left), 32'(vecs[i].wl));
        end
        check("basic fifo leftover", 32'(wptr - rptr), 32'd1);
        check("basic fifo head",     fifo_data,        32'hDEAD);
        @(negedge clk);
        wptr = rptr;

        // Partial burst leaving words behind, then drain the rest
        for (int k = 0; k < 8; k++) push(32'hAAAA_0000 + DW'(k));
        base = cap_n;
        run_burst(8'd3, 1'b0, "partial");
        check_stream(base, 3, 32'hAAAA_0000, "partial");
        check("partial leftover", 32'(wptr - rptr), 32'd5);
        check("partial empty",    32'(fifo_empty),  32'd0);
        base = cap_n;
        run_burst(8'd5, 1'b0, "rest");
        check_stream(base, 5, 32'hAAAA_0003, "rest");
        check("rest empty", 32'(fifo_empty), 32'd1);

        // Backpressure with out_ready pattern 1,0,0,1,0,1,1
        for (int k = 0; k < 4; k++) push(32'hC0 + DW'(k));
        base = cap_n;
        run_burst(8'd4, 1'b1, "bp");
        check_stream(base, 4, 32'hC0, "bp");
        check("bp no pop during stall", 32'(stall_rd_n), 32'd0);
        check("bp stable during stall", 32'(unstable_n), 32'd0);

        // Starvation: empty FIFO, extra start while busy must be ignored
        base = cap_n;
        d0   = done_n;
        bad  = 0;
        @(negedge clk);
        start     = 1'b1;
        burst_len = 8'd2;
        @(negedge clk);
        start     = 1'b0;
        burst_len = 8'd7;
        for (int c = 0; c < 10; c++) begin
            start     = (c == 3);
            burst_len = 8'd5;
            #1;
            if (fifo_rd || !busy) bad = bad + 1;
            @(negedge clk);
        end
        start = 1'b0;
        check("starve idle pops", 32'(bad), 32'd0);
        check("starve words_left", 32'(words_left), 32'd2);
        push(32'h11);
        repeat (10) @(negedge clk);
        #1;
        check("starve mid busy",       32'(busy),       32'd1);
        check("starve mid words_left", 32'(words_left), 32'd1);
        push(32'h22);
        bad = 1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #1;
            if (done) begin
                bad = 0;
                break;
            end
        end
        check("starve done reached", 32'(bad), 32'd0);
        repeat (5) @(negedge clk);
        check("starve one done", 32'(done_n - d0), 32'd1);
        check("starve idle",     32'(busy),        32'd0);
        check("starve count",    32'(cap_n - base), 32'd2);
        check("starve word0",    cap_data[8'(base)],     32'h11);
        check("starve word1",    cap_data[8'(base + 1)], 32'h22);
        check("starve last0",    32'(cap_last[8'(base)]),     32'd0);
        check("starve last1",    32'(cap_last[8'(base + 1)]), 32'd1);

        // Reset after the second of eight pops
        for (int k = 0; k < 8; k++) push(32'hB0 + DW'(k));
        rbase = rptr;
        d0    = done_n;
        @(negedge clk);
        start     = 1'b1;
        burst_len = 8'd8;
        @(negedge clk);
        start = 1'b0;
        bad   = 1;
        for (int c = 0; c < 20; c++) begin
            if (rptr - rbase == 6'd2) begin
                bad = 0;
                break;
            end
            @(negedge clk);
        end
        check("rst two pops seen", 32'(bad), 32'd0);
        rst = 1'b0;
        #1;
        check("rst fifo_rd forced", 32'(fifo_rd), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst out_valid",  32'(out_valid),    32'd0);
        check("rst busy",       32'(busy),         32'd0);
        check("rst words_left", 32'(words_left),   32'd0);
        check("rst no pop",     32'(rptr - rbase), 32'd2);
        repeat (4) @(negedge clk);
        check("rst no done",    32'(done_n - d0),  32'd0);
        check("rst stays idle", 32'(busy),         32'd0);
        wptr = rptr;

        // Fresh burst after reset
        push(32'd1); push(32'd2); push(32'd3); push(32'd4);
        base = cap_n;
        run_burst(8'd4, 1'b0, "post");
        check_stream(base, 4, 32'd1, "post");
        check("post empty", 32'(fifo_empty), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
